// File: rtl/relu_objective_if.sv
// Handshake bundle between a neuron node, the relu_objective block and its consumer.
// Streams: product (node -> block), result (block -> consumer), target (trainer -> block),
// delta (block -> node); each stream is valid/ready with 16-bit signed Q8.8 data.
interface relu_objective_if;
  // Training-mode flag, only meaningful alongside an accepted product.
  logic        train;

  logic        product_valid;
  logic [15:0] product_data;
  logic        product_ready;

  logic        result_valid;
  logic [15:0] result_data;
  logic        result_ready;

  logic        target_valid;
  logic [15:0] target_data;
  logic        target_ready;

  logic        delta_valid;
  logic [15:0] delta_data;
  logic        delta_ready;

  // Environment side: node, trainer and result consumer.
  modport master (
    output train,
    output product_valid, product_data,
    input  product_ready,
    input  result_valid, result_data,
    output result_ready,
    output target_valid, target_data,
    input  target_ready,
    input  delta_valid, delta_data,
    output delta_ready
  );

  // Block side.
  modport slave (
    input  train,
    input  product_valid, product_data,
    output product_ready,
    output result_valid, result_data,
    input  result_ready,
    input  target_valid, target_data,
    output target_ready,
    output delta_valid, delta_data,
    input  delta_ready
  );
endinterface

// File: rtl/relu_objective.sv
// Purpose: leaky-ReLU activation of a node's product; in training mode turns a target into the node's delta.
// Latency: result 1 cycle after product transfer; delta 1 cycle after target transfer.
// Backpressure: one transaction in flight; product_ready only in IDL, outputs hold while their ready is low.
// Ports: clock; reset (synchronous, active-low); bus (relu_objective_if.slave) carrying
//   train, product/result/target/delta valid-ready-data streams.
module relu_objective #(
  parameter int LEAK  = 0,  // negative slope 2^-LEAK; 0 selects pure ReLU
  parameter int SHIFT = 0   // learning-rate scaling applied to the delta
) (
  input  logic           clock,
  input  logic           reset,
  relu_objective_if.slave bus
);

  typedef enum logic [1:0] {
    IDL = 2'd0,
    RES = 2'd1,
    TGT = 2'd2,
    DEL = 2'd3
  } state_t;

  state_t             state;
  logic signed [15:0] prod_q;   // product of the transaction in flight
  logic               train_q;  // mode captured with that product

  // Activation of a Q8.8 value; the arithmetic shift floors toward -inf.
  function automatic logic signed [15:0] act_f(input logic signed [15:0] p);
    if (!p[15])
      return p;
    else if (LEAK == 0)
      return '0;
    else
      return p >>> LEAK;
  endfunction

  logic signed [15:0] act_stored;
  logic signed [16:0] err_wide;
  logic signed [15:0] err_sat;
  logic signed [15:0] grad;
  logic signed [15:0] delta_next;

  always_comb begin
    act_stored = act_f(prod_q);
    // Sign-extend both operands so the difference cannot wrap before saturation.
    err_wide   = {bus.target_data[15], bus.target_data} - {act_stored[15], act_stored};
    // Bits 16 and 15 disagree exactly when the result left the 16-bit range.
    if (err_wide[16] != err_wide[15])
      err_sat = err_wide[16] ? 16'sh8000 : 16'sh7FFF;
    else
      err_sat = err_wide[15:0];
    // Derivative: 1 for strictly positive products; zero is treated as the negative side.
    if (!prod_q[15] && (prod_q != 16'sd0))
      grad = err_sat;
    else if (LEAK == 0)
      grad = '0;
    else
      grad = err_sat >>> LEAK;
    delta_next = grad >>> SHIFT;
  end

  // Ready flags come straight from the state register, so they never glitch.
  assign bus.product_ready = (state == IDL);
  assign bus.target_ready  = (state == TGT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      // Reset wins over any handshake on the same edge.
      state            <= IDL;
      bus.result_valid <= 1'b0;
      bus.result_data  <= '0;
      bus.delta_valid  <= 1'b0;
      bus.delta_data   <= '0;
      prod_q           <= '0;
      train_q          <= 1'b0;
    end else begin
      case (state)
        IDL: begin
          if (bus.product_valid) begin
            prod_q           <= bus.product_data;
            train_q          <= bus.train;
            bus.result_data  <= act_f(bus.product_data);
            bus.result_valid <= 1'b1;
            state            <= RES;
          end
        end
        RES: begin
          if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            state            <= train_q ? TGT : IDL;
          end
        end
        TGT: begin
          if (bus.target_valid) begin
            bus.delta_data  <= delta_next;
            bus.delta_valid <= 1'b1;
            state           <= DEL;
          end
        end
        DEL: begin
          if (bus.delta_ready) begin
            bus.delta_valid <= 1'b0;
            state           <= IDL;
          end
        end
        default: $fatal(1, "relu_objective: illegal state encoding");
      endcase
    end
  end

endmodule
